// File: rtl/gpio_pkg.sv
// Shared definitions for the GPIO controller: register map and default pin count.
package gpio_pkg;

  localparam int GPIO_WIDTH = 32;

  localparam logic [2:0] GPIO_OUT      = 3'd0;
  localparam logic [2:0] GPIO_DIR      = 3'd1;
  localparam logic [2:0] GPIO_IN       = 3'd2;
  localparam logic [2:0] GPIO_IRQ_EN   = 3'd3;
  localparam logic [2:0] GPIO_EDGE_SEL = 3'd4;
  localparam logic [2:0] GPIO_STATUS   = 3'd5;
  localparam logic [2:0] GPIO_OUT_SET  = 3'd6;
  localparam logic [2:0] GPIO_OUT_CLR  = 3'd7;

endpackage

// File: rtl/gpio_sync.sv
// Multi-stage synchroniser bringing asynchronous pad inputs into the clk domain.
module gpio_sync #(
  parameter int WIDTH       = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] stage_d [SYNC_STAGES];
  logic [WIDTH-1:0] stage_q [SYNC_STAGES];

  always_comb begin
    stage_d[0] = d;
    for (int i = 1; i < SYNC_STAGES; i++) begin
      stage_d[i] = stage_q[i-1];
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < SYNC_STAGES; i++) begin
      if (!reset) begin
        stage_q[i] <= '0;
      end else begin
        stage_q[i] <= stage_d[i];
      end
    end
  end

  assign q = stage_q[SYNC_STAGES-1];

endmodule

// File: rtl/gpio_ctrl.sv
// Register-mapped GPIO controller: direction, atomic set/clear, synced inputs and
// per-pin edge interrupts on a simple we/re peripheral bus.
module gpio_ctrl
  import gpio_pkg::*;
#(
  parameter int WIDTH       = GPIO_WIDTH,
  parameter int SYNC_STAGES = 2,
  parameter int ADDR_W      = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic              re,
  input  logic [ADDR_W-1:0] addr,
  input  logic [WIDTH-1:0]  data_in,
  output logic [WIDTH-1:0]  data_out,
  output logic              rd_valid,
  input  logic [WIDTH-1:0]  gpio_in,
  output logic [WIDTH-1:0]  gpio_out,
  output logic [WIDTH-1:0]  gpio_oe,
  output logic              irq
);

  // Edge detection stays off until prev holds a real pin sample, so pins already
  // high at reset release do not look like rising edges.
  localparam int                PRIME_W    = $clog2(SYNC_STAGES + 2);
  localparam logic [PRIME_W-1:0] PRIME_DONE = PRIME_W'(SYNC_STAGES + 1);

  logic [WIDTH-1:0]   sync_in;
  logic [WIDTH-1:0]   out_d, out_q;
  logic [WIDTH-1:0]   dir_d, dir_q;
  logic [WIDTH-1:0]   irq_en_d, irq_en_q;
  logic [WIDTH-1:0]   edge_sel_d, edge_sel_q;
  logic [WIDTH-1:0]   status_d, status_q;
  logic [WIDTH-1:0]   prev_d, prev_q;
  logic [PRIME_W-1:0] prime_d, prime_q;
  logic [WIDTH-1:0]   data_out_d, data_out_q;
  logic               rd_valid_d, rd_valid_q;
  logic [WIDTH-1:0]   rise, fall, edge_evt, w1c;

  gpio_sync #(
    .WIDTH      (WIDTH),
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk  (clk),
    .reset(reset),
    .d    (gpio_in),
    .q    (sync_in)
  );

  always_comb begin
    out_d      = out_q;
    dir_d      = dir_q;
    irq_en_d   = irq_en_q;
    edge_sel_d = edge_sel_q;
    data_out_d = data_out_q;
    rd_valid_d = re;
    prev_d     = sync_in;
    prime_d    = (prime_q == PRIME_DONE) ? prime_q : prime_q + 1'b1;
    w1c        = '0;

    rise     = sync_in & ~prev_q;
    fall     = ~sync_in & prev_q;
    edge_evt = (prime_q == PRIME_DONE) ? ((rise & ~edge_sel_q) | (fall & edge_sel_q)) : '0;

    if (we) begin
      case (addr)
        GPIO_OUT:      out_d      = data_in;
        GPIO_DIR:      dir_d      = data_in;
        GPIO_IRQ_EN:   irq_en_d   = data_in;
        GPIO_EDGE_SEL: edge_sel_d = data_in;
        GPIO_STATUS:   w1c        = data_in;
        GPIO_OUT_SET:  out_d      = out_q | data_in;
        GPIO_OUT_CLR:  out_d      = out_q & ~data_in;
        default:       ;
      endcase
    end

    // A new edge in the same cycle as its clear keeps the bit set.
    status_d = (status_q & ~w1c) | edge_evt;

    if (re) begin
      case (addr)
        GPIO_OUT:      data_out_d = out_q;
        GPIO_DIR:      data_out_d = dir_q;
        GPIO_IN:       data_out_d = sync_in;
        GPIO_IRQ_EN:   data_out_d = irq_en_q;
        GPIO_EDGE_SEL: data_out_d = edge_sel_q;
        GPIO_STATUS:   data_out_d = status_q;
        default:       data_out_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      out_q      <= '0;
      dir_q      <= '0;
      irq_en_q   <= '0;
      edge_sel_q <= '0;
      status_q   <= '0;
      prev_q     <= '0;
      prime_q    <= '0;
      data_out_q <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      out_q      <= out_d;
      dir_q      <= dir_d;
      irq_en_q   <= irq_en_d;
      edge_sel_q <= edge_sel_d;
      status_q   <= status_d;
      prev_q     <= prev_d;
      prime_q    <= prime_d;
      data_out_q <= data_out_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  assign gpio_out = out_q;
  assign gpio_oe  = dir_q;
  assign data_out = data_out_q;
  assign rd_valid = rd_valid_q;
  assign irq      = |(status_q & irq_en_q);

endmodule

// File: tb/tb_gpio_ctrl.sv
// Self-checking bench for gpio_ctrl: register vector table plus edge/interrupt sequences.
module tb_gpio_ctrl;

  localparam logic [2:0] A_OUT = 3'd0, A_DIR = 3'd1, A_IN = 3'd2, A_IEN = 3'd3,
                         A_ESEL = 3'd4, A_STAT = 3'd5, A_SET = 3'd6, A_CLR = 3'd7;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        we = 1'b0;
  logic        re = 1'b0;
  logic [2:0]  addr = '0;
  logic [31:0] data_in = '0;
  logic [31:0] data_out;
  logic        rd_valid;
  logic [31:0] gpio_in = '0;
  logic [31:0] gpio_out;
  logic [31:0] gpio_oe;
  logic        irq;

  int errors = 0;
  int checks = 0;
  logic [31:0] sb[$];

  typedef struct {
    logic        w;
    logic        r;
    logic [2:0]  a;
    logic [31:0] wdata;
    logic [31:0] rexp;
    logic [31:0] eout;
    logic [31:0] eoe;
    logic        eirq;
  } vec_t;

  vec_t tbl[23];

  gpio_ctrl dut (
    .clk     (clk),
    .reset   (reset),
    .we      (we),
    .re      (re),
    .addr    (addr),
    .data_in (data_in),
    .data_out(data_out),
    .rd_valid(rd_valid),
    .gpio_in (gpio_in),
    .gpio_out(gpio_out),
    .gpio_oe (gpio_oe),
    .irq     (irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One clock: checks rd_valid against the read issued this cycle and pops the scoreboard.
  task automatic tick();
    logic exp_v;
    exp_v = re & reset;
    @(posedge clk);
    #1;
    chk("rd_valid", 32'(rd_valid), 32'(exp_v));
    if (rd_valid) begin
      if (sb.size() == 0) begin
        chk("rd_unexpected", 32'(rd_valid), 32'h0);
      end else begin
        chk("data_out", data_out, sb.pop_front());
      end
    end
    if (!reset) sb.delete();
  endtask

  task automatic op(input logic w, input logic r, input logic [2:0] a,
                    input logic [31:0] wd, input logic [31:0] rexp);
    we = w; re = r; addr = a; data_in = wd;
    if (r) sb.push_back(rexp);
    tick();
    we = 1'b0; re = 1'b0; data_in = '0;
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] wd);
    op(1'b1, 1'b0, a, wd, 32'h0);
  endtask

  task automatic rd(input logic [2:0] a, input logic [31:0] rexp);
    op(1'b0, 1'b1, a, 32'h0, rexp);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    tbl[0]  = '{1'b1, 1'b0, A_OUT,  32'hA5A5A5A5, 32'h0,        32'hA5A5A5A5, 32'h0,        1'b0};
    tbl[1]  = '{1'b1, 1'b0, A_DIR,  32'hFFFF0000, 32'h0,        32'hA5A5A5A5, 32'hFFFF0000, 1'b0};
    tbl[2]  = '{1'b0, 1'b1, A_OUT,  32'h0,        32'hA5A5A5A5, 32'hA5A5A5A5, 32'hFFFF0000, 1'b0};
    tbl[3]  = '{1'b0, 1'b1, A_DIR,  32'h0,        32'hFFFF0000, 32'hA5A5A5A5, 32'hFFFF0000, 1'b0};
    tbl[4]  = '{1'b1, 1'b0, A_OUT,  32'h12345678, 32'h0,        32'h12345678, 32'hFFFF0000, 1'b0};
    tbl[5]  = '{1'b1, 1'b0, A_SET,  32'h0000000F, 32'h0,        32'h1234567F, 32'hFFFF0000, 1'b0};
    tbl[6]  = '{1'b1, 1'b0, A_CLR,  32'h10000000, 32'h0,        32'h0234567F, 32'hFFFF0000, 1'b0};
    tbl[7]  = '{1'b0, 1'b1, A_SET,  32'h0,        32'h0,        32'h0234567F, 32'hFFFF0000, 1'b0};
    tbl[8]  = '{1'b0, 1'b1, A_CLR,  32'h0,        32'h0,        32'h0234567F, 32'hFFFF0000, 1'b0};
    tbl[9]  = '{1'b0, 1'b1, A_OUT,  32'h0,        32'h0234567F, 32'h0234567F, 32'hFFFF0000, 1'b0};
    tbl[10] = '{1'b1, 1'b0, A_IN,   32'hDEADBEEF, 32'h0,        32'h0234567F, 32'hFFFF0000, 1'b0};
    tbl[11] = '{1'b0, 1'b1, A_IN,   32'h0,        32'h0F0F0000, 32'h0234567F, 32'hFFFF0000, 1'b0};
    tbl[12] = '{1'b1, 1'b1, A_OUT,  32'h0,        32'h0234567F, 32'h0,        32'hFFFF0000, 1'b0};
    tbl[13] = '{1'b0, 1'b1, A_STAT, 32'h0,        32'h0F0F0000, 32'h0,        32'hFFFF0000, 1'b0};
    tbl[14] = '{1'b1, 1'b0, A_IEN,  32'h00010000, 32'h0,        32'h0,        32'hFFFF0000, 1'b1};
    tbl[15] = '{1'b0, 1'b1, A_IEN,  32'h0,        32'h00010000, 32'h0,        32'hFFFF0000, 1'b1};
    tbl[16] = '{1'b1, 1'b0, A_STAT, 32'h0F000000, 32'h0,        32'h0,        32'hFFFF0000, 1'b1};
    tbl[17] = '{1'b0, 1'b1, A_STAT, 32'h0,        32'h000F0000, 32'h0,        32'hFFFF0000, 1'b1};
    tbl[18] = '{1'b1, 1'b0, A_STAT, 32'h00010000, 32'h0,        32'h0,        32'hFFFF0000, 1'b0};
    tbl[19] = '{1'b1, 1'b0, A_ESEL, 32'h00000001, 32'h0,        32'h0,        32'hFFFF0000, 1'b0};
    tbl[20] = '{1'b0, 1'b1, A_ESEL, 32'h0,        32'h00000001, 32'h0,        32'hFFFF0000, 1'b0};
    tbl[21] = '{1'b1, 1'b0, A_ESEL, 32'h0,        32'h0,        32'h0,        32'hFFFF0000, 1'b0};
    tbl[22] = '{1'b1, 1'b0, A_IEN,  32'h00000001, 32'h0,        32'h0,        32'hFFFF0000, 1'b0};

    // Reset state
    reset = 1'b0;
    idle(3);
    chk("rst_gpio_out", gpio_out, 32'h0);
    chk("rst_gpio_oe", gpio_oe, 32'h0);
    chk("rst_irq", 32'(irq), 32'h0);
    reset = 1'b1;
    idle(5);
    gpio_in = 32'h0F0F0000;

    // Register vectors
    for (int i = 0; i < 23; i++) begin
      op(tbl[i].w, tbl[i].r, tbl[i].a, tbl[i].wdata, tbl[i].rexp);
      chk($sformatf("vec%0d_gpio_out", i), gpio_out, tbl[i].eout);
      chk($sformatf("vec%0d_gpio_oe", i), gpio_oe, tbl[i].eoe);
      chk($sformatf("vec%0d_irq", i), 32'(irq), 32'(tbl[i].eirq));
    end

    // data_out holds its value while idle
    idle(1);
    chk("data_out_hold", data_out, 32'h00000001);

    gpio_in = 32'h0;
    idle(4);
    wr(A_STAT, 32'hFFFFFFFF);
    chk("status_clr_irq", 32'(irq), 32'h0);
    rd(A_STAT, 32'h0);

    // Rising edge on pin 0: STATUS/irq exactly three cycles later
    gpio_in = 32'h1;
    idle(2);
    chk("rise_irq_early", 32'(irq), 32'h0);
    idle(1);
    chk("rise_irq", 32'(irq), 32'h1);
    rd(A_STAT, 32'h1);
    wr(A_STAT, 32'h1);
    chk("rise_w1c_irq", 32'(irq), 32'h0);

    // Falling edge on pin 0
    wr(A_ESEL, 32'h1);
    gpio_in = 32'h0;
    idle(2);
    chk("fall_irq_early", 32'(irq), 32'h0);
    idle(1);
    chk("fall_irq", 32'(irq), 32'h1);
    rd(A_STAT, 32'h1);
    wr(A_STAT, 32'h1);
    chk("fall_w1c_irq", 32'(irq), 32'h0);

    // STATUS latches independent of IRQ_EN
    wr(A_IEN, 32'h0);
    gpio_in = 32'h2;
    idle(4);
    chk("masked_irq", 32'(irq), 32'h0);
    rd(A_STAT, 32'h2);
    wr(A_IEN, 32'h2);
    chk("unmask_irq", 32'(irq), 32'h1);
    wr(A_STAT, 32'h2);
    chk("unmask_w1c_irq", 32'(irq), 32'h0);
    gpio_in = 32'h0;
    idle(4);

    // W1C in the same cycle the rising edge lands: set wins
    wr(A_ESEL, 32'h0);
    wr(A_IEN, 32'h1);
    gpio_in = 32'h1;
    idle(2);
    wr(A_STAT, 32'h1);
    chk("coincide_irq", 32'(irq), 32'h1);
    rd(A_STAT, 32'h1);

    // Reset with pins held high, aborting a read in flight
    gpio_in = 32'hFFFFFFFF;
    reset = 1'b0;
    re = 1'b1; addr = A_OUT;
    tick();
    re = 1'b0;
    idle(2);
    chk("rst2_gpio_out", gpio_out, 32'h0);
    chk("rst2_gpio_oe", gpio_oe, 32'h0);
    chk("rst2_irq", 32'(irq), 32'h0);
    chk("rst2_data_out", data_out, 32'h0);
    reset = 1'b1;
    idle(6);
    rd(A_STAT, 32'h0);
    rd(A_IN, 32'hFFFFFFFF);
    wr(A_IEN, 32'hFFFFFFFF);
    chk("rst2_no_edge_irq", 32'(irq), 32'h0);

    idle(1);
    chk("scoreboard_empty", 32'(sb.size()), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
